// File: rtl/core_ctrl_pkg.sv
// Shared controller definitions for the multi-cycle RV32I lab core:
// state encoding, opcode constants, datapath mux/ALU encodings and the per-state control decode.
package core_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_EXEC_I   = 4'd4,
    S_WB_ALU   = 4'd5,
    S_MEM_ADDR = 4'd6,
    S_MEM_RD   = 4'd7,
    S_WB_MEM   = 4'd8,
    S_MEM_WR   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_TRAP     = 4'd12
  } state_t;

  localparam logic [6:0] OP_R_TYPE = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_RFUNC = 2'b10;
  localparam logic [1:0] ALU_OP_IFUNC = 2'b11;

  localparam logic [1:0] SRC_A_PC     = 2'b00;
  localparam logic [1:0] SRC_A_RS1    = 2'b01;
  localparam logic [1:0] SRC_A_OLD_PC = 2'b10;

  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_FOUR = 2'b01;
  localparam logic [1:0] SRC_B_IMM  = 2'b10;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       pc_src;
    logic       pc_jump;
    logic       reg_write;
    logic       mem_to_reg;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

  // Input-independent control for a state; fetch/branch PC strobes are qualified in the top.
  function automatic ctrl_t ctrl_decode(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_req   = 1'b1;
        c.alu_src_a = SRC_A_PC;
        c.alu_src_b = SRC_B_FOUR;
        c.alu_op    = ALU_OP_ADD;
      end
      S_DECODE: begin
        c.alu_src_a = SRC_A_OLD_PC;
        c.alu_src_b = SRC_B_IMM;
        c.alu_op    = ALU_OP_ADD;
      end
      S_EXEC_R: begin
        c.alu_src_a = SRC_A_RS1;
        c.alu_src_b = SRC_B_RS2;
        c.alu_op    = ALU_OP_RFUNC;
      end
      S_EXEC_I: begin
        c.alu_src_a = SRC_A_RS1;
        c.alu_src_b = SRC_B_IMM;
        c.alu_op    = ALU_OP_IFUNC;
      end
      S_WB_ALU: c.reg_write = 1'b1;
      S_MEM_ADDR: begin
        c.alu_src_a = SRC_A_RS1;
        c.alu_src_b = SRC_B_IMM;
        c.alu_op    = ALU_OP_ADD;
      end
      S_MEM_RD: begin
        c.mem_req = 1'b1;
        c.iord    = 1'b1;
      end
      S_WB_MEM: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        c.mem_req = 1'b1;
        c.mem_we  = 1'b1;
        c.iord    = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a = SRC_A_RS1;
        c.alu_src_b = SRC_B_RS2;
        c.alu_op    = ALU_OP_SUB;
        c.pc_src    = 1'b1;
      end
      S_JUMP: begin
        c.pc_src    = 1'b1;
        c.pc_jump   = 1'b1;
        c.reg_write = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// Controller <-> datapath/memory signal bundle; master is the controller, slave the datapath side.
interface multicycle_ctrl_fsm_if #(
  parameter int INSTR_W = 32
);
  logic [INSTR_W-1:0] instr_i;
  logic               alu_zero_i;
  logic               mem_ready_i;
  logic               mem_req_o;
  logic               mem_we_o;
  logic               iord_o;
  logic               ir_write_o;
  logic               pc_write_o;
  logic               pc_src_o;
  logic               reg_write_o;
  logic               mem_to_reg_o;
  logic [1:0]         alu_src_a_o;
  logic [1:0]         alu_src_b_o;
  logic [1:0]         alu_op_o;
  logic               mem_err_o;
  logic [3:0]         state_o;

  modport master (
    input  instr_i, alu_zero_i, mem_ready_i,
    output mem_req_o, mem_we_o, iord_o, ir_write_o, pc_write_o, pc_src_o,
           reg_write_o, mem_to_reg_o, alu_src_a_o, alu_src_b_o, alu_op_o,
           mem_err_o, state_o
  );

  modport slave (
    output instr_i, alu_zero_i, mem_ready_i,
    input  mem_req_o, mem_we_o, iord_o, ir_write_o, pc_write_o, pc_src_o,
           reg_write_o, mem_to_reg_o, alu_src_a_o, alu_src_b_o, alu_op_o,
           mem_err_o, state_o
  );
endinterface

// File: rtl/multicycle_ctrl_fsm_mem_watchdog.sv
// Memory-wait watchdog: counts stalled request cycles, flags expiry and emits a one-cycle error pulse.
module mem_watchdog #(
  parameter int MEM_WAIT_MAX = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic req,
  input  logic ready,
  output logic expire,
  output logic err
);

  localparam int CNT_W = (MEM_WAIT_MAX < 2) ? 1 : $clog2(MEM_WAIT_MAX + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MEM_WAIT_MAX - 1);

  logic [CNT_W-1:0] cnt;

  // Expiry is the last permitted stall cycle; a ready in that cycle takes precedence.
  assign expire = req && !ready && (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      err <= 1'b0;
    end else begin
      err <= expire;
      if (clear)
        cnt <= '0;
      else if (req && !ready)
        cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle control FSM for the RV32I lab core (FETCH/DECODE/EXEC/MEM/WB sequencing).
// Define ILLEGAL_TRAP_EN to send unsupported opcodes to a sticky TRAP state instead of treating them as NOPs.
module multicycle_ctrl_fsm
  import core_ctrl_pkg::*;
#(
  parameter int INSTR_W      = 32,
  parameter int MEM_WAIT_MAX = 8
) (
  input logic                  clk_i,
  input logic                  rst_i,
  multicycle_ctrl_fsm_if.master bus
);

  state_t             state_q;
  state_t             state_d;
  ctrl_t              ctrl_q;
  logic [INSTR_W-1:0] instr;
  logic [6:0]         opcode;
  logic               expire;
  logic               wd_clear;
  logic               wd_err;

  assign instr  = bus.instr_i;
  assign opcode = instr[6:0];

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  if (bus.mem_ready_i) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_R_TYPE:         state_d = S_EXEC_R;
          OP_I_ALU:          state_d = S_EXEC_I;
          OP_LOAD, OP_STORE: state_d = S_MEM_ADDR;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JUMP;
`ifdef ILLEGAL_TRAP_EN
          default:           state_d = S_TRAP;
`else
          default:           state_d = S_FETCH;
`endif
        endcase
      end
      S_EXEC_R, S_EXEC_I: state_d = S_WB_ALU;
      S_WB_ALU, S_WB_MEM, S_BRANCH, S_JUMP: state_d = S_FETCH;
      S_MEM_ADDR: state_d = opcode[5] ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: begin
        if (bus.mem_ready_i)
          state_d = S_WB_MEM;
        else if (expire)
          state_d = S_FETCH;
      end
      S_MEM_WR: if (bus.mem_ready_i || expire) state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_IDLE;
    endcase
  end

  // A fetch timeout re-enters FETCH without a state change, so expiry also restarts the count.
  assign wd_clear = (state_d != state_q) || expire;

  mem_watchdog #(
    .MEM_WAIT_MAX(MEM_WAIT_MAX)
  ) u_watchdog (
    .clk   (clk_i),
    .rst   (rst_i),
    .clear (wd_clear),
    .req   (ctrl_q.mem_req),
    .ready (bus.mem_ready_i),
    .expire(expire),
    .err   (wd_err)
  );

  // Control outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_decode(state_d);
    end
  end

  assign bus.mem_req_o    = ctrl_q.mem_req;
  assign bus.mem_we_o     = ctrl_q.mem_we;
  assign bus.iord_o       = ctrl_q.iord;
  assign bus.pc_src_o     = ctrl_q.pc_src;
  assign bus.reg_write_o  = ctrl_q.reg_write;
  assign bus.mem_to_reg_o = ctrl_q.mem_to_reg;
  assign bus.alu_src_a_o  = ctrl_q.alu_src_a;
  assign bus.alu_src_b_o  = ctrl_q.alu_src_b;
  assign bus.alu_op_o     = ctrl_q.alu_op;
  assign bus.mem_err_o    = wd_err;
  assign bus.state_o      = state_q;
  assign bus.ir_write_o   = (state_q == S_FETCH) && bus.mem_ready_i;
  assign bus.pc_write_o   = ctrl_q.pc_jump
                          || ((state_q == S_FETCH) && bus.mem_ready_i)
                          || ((state_q == S_BRANCH) && bus.alu_zero_i);

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Self-checking bench for multicycle_ctrl_fsm: directed and randomized instruction streams checked
// cycle by cycle against an instruction-level trace model.
module tb_multicycle_ctrl_fsm;
  import core_ctrl_pkg::*;

  localparam int MAXW = 8;

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_ADDI = 32'h00508093;
  localparam logic [31:0] I_LW   = 32'h0000A183;
  localparam logic [31:0] I_SW   = 32'h0020A023;
  localparam logic [31:0] I_BEQ  = 32'h00208463;
  localparam logic [31:0] I_JAL  = 32'h008000EF;
  localparam logic [31:0] I_BAD  = 32'h0000007F;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multicycle_ctrl_fsm_if #(.INSTR_W(32)) bus ();

  multicycle_ctrl_fsm #(
    .INSTR_W     (32),
    .MEM_WAIT_MAX(MAXW)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;

  logic [14:0] obs_vec;
  assign obs_vec = {bus.mem_req_o, bus.mem_we_o, bus.iord_o, bus.ir_write_o, bus.pc_write_o,
                    bus.pc_src_o, bus.reg_write_o, bus.mem_to_reg_o, bus.alu_src_a_o,
                    bus.alu_src_b_o, bus.alu_op_o, bus.mem_err_o};

  typedef struct {
    state_t      st;
    logic        rdy;
    logic        zero;
    logic [14:0] vec;
  } step_t;

  step_t q[$];
  bit    err_next;

  function automatic logic [14:0] ev(input logic req, we, iord, irw, pcw, pcs, rw, m2r,
                                     input logic [1:0] a, b, op);
    return {req, we, iord, irw, pcw, pcs, rw, m2r, a, b, op, 1'b0};
  endfunction

  function automatic logic rnd();
    return 1'($urandom);
  endfunction

  function automatic void push(input state_t st, input logic rdy, input logic zero,
                               input logic [14:0] vec);
    step_t s;
    s.st   = st;
    s.rdy  = rdy;
    s.zero = zero;
    s.vec  = vec;
    if (err_next) begin
      s.vec[0] = 1'b1;
      err_next = 1'b0;
    end
    q.push_back(s);
  endfunction

  // A memory phase stalls for w cycles then completes, or times out after MAXW stalls.
  function automatic bit mem_phase(input state_t st, input logic [14:0] stall_v,
                                   input logic [14:0] ok_v, input int w);
    int n;
    n = (w < MAXW) ? w : MAXW;
    for (int i = 0; i < n; i++) push(st, 1'b0, rnd(), stall_v);
    if (w >= MAXW) begin
      err_next = 1'b1;
      return 1'b1;
    end
    push(st, 1'b1, rnd(), ok_v);
    return 1'b0;
  endfunction

  function automatic void plan(input logic [31:0] ins, input int fw, input int mw,
                               input logic zero);
    bit to;
    int w;
    to = 1'b1;
    w  = fw;
    while (to) begin
      to = mem_phase(S_FETCH, ev(1,0,0,0,0,0,0,0, 2'd0,2'd1,2'd0),
                     ev(1,0,0,1,1,0,0,0, 2'd0,2'd1,2'd0), w);
      w = 0;
    end
    push(S_DECODE, rnd(), rnd(), ev(0,0,0,0,0,0,0,0, 2'd2,2'd2,2'd0));
    case (ins[6:0])
      7'b0110011: begin
        push(S_EXEC_R, rnd(), rnd(), ev(0,0,0,0,0,0,0,0, 2'd1,2'd0,2'd2));
        push(S_WB_ALU, rnd(), rnd(), ev(0,0,0,0,0,0,1,0, 2'd0,2'd0,2'd0));
      end
      7'b0010011: begin
        push(S_EXEC_I, rnd(), rnd(), ev(0,0,0,0,0,0,0,0, 2'd1,2'd2,2'd3));
        push(S_WB_ALU, rnd(), rnd(), ev(0,0,0,0,0,0,1,0, 2'd0,2'd0,2'd0));
      end
      7'b0000011: begin
        push(S_MEM_ADDR, rnd(), rnd(), ev(0,0,0,0,0,0,0,0, 2'd1,2'd2,2'd0));
        to = mem_phase(S_MEM_RD, ev(1,0,1,0,0,0,0,0, 2'd0,2'd0,2'd0),
                       ev(1,0,1,0,0,0,0,0, 2'd0,2'd0,2'd0), mw);
        if (!to) push(S_WB_MEM, rnd(), rnd(), ev(0,0,0,0,0,0,1,1, 2'd0,2'd0,2'd0));
      end
      7'b0100011: begin
        push(S_MEM_ADDR, rnd(), rnd(), ev(0,0,0,0,0,0,0,0, 2'd1,2'd2,2'd0));
        to = mem_phase(S_MEM_WR, ev(1,1,1,0,0,0,0,0, 2'd0,2'd0,2'd0),
                       ev(1,1,1,0,0,0,0,0, 2'd0,2'd0,2'd0), mw);
      end
      7'b1100011: push(S_BRANCH, rnd(), zero, ev(0,0,0,0,zero,1,0,0, 2'd1,2'd0,2'd1));
      7'b1101111: push(S_JUMP, rnd(), rnd(), ev(0,0,0,0,1,1,1,0, 2'd0,2'd0,2'd0));
      default: begin
`ifdef ILLEGAL_TRAP_EN
        for (int i = 0; i < 3; i++) push(S_TRAP, rnd(), rnd(), 15'd0);
`endif
      end
    endcase
  endfunction

  task automatic check_output(input string tag, input state_t est, input logic [14:0] evec);
    checks++;
    assert (bus.state_o === est)
    else begin
      errors++;
      $error("[TB] FAIL %s state: observed %0d expected %0d", tag, bus.state_o, est);
    end
    checks++;
    assert (obs_vec === evec)
    else begin
      errors++;
      $error("[TB] FAIL %s outputs in state %0d: observed %b expected %b", tag, est, obs_vec, evec);
    end
  endtask

  task automatic apply_stimulus(input logic rdy, input logic zero);
    bus.mem_ready_i = rdy;
    bus.alu_zero_i  = zero;
  endtask

  // Plays the planned trace; abort_wr asserts reset in the middle of the first MEM_WR cycle.
  task automatic run_queue(input string tag, input bit abort_wr);
    step_t s;
    while (q.size() > 0) begin
      s = q.pop_front();
      apply_stimulus(s.rdy, s.zero);
      @(negedge clk);
      check_output(tag, s.st, s.vec);
      if (abort_wr && s.st == S_MEM_WR) begin
        #2 rst = 1'b1;
        #1 check_output({tag, "_rst"}, S_IDLE, 15'd0);
        q.delete();
        err_next = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        push(S_IDLE, rnd(), rnd(), 15'd0);
        abort_wr = 1'b0;
      end else begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    q.delete();
    err_next = 1'b0;
    apply_stimulus(1'b1, 1'b1);
    #1 check_output("reset", S_IDLE, 15'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    push(S_IDLE, rnd(), rnd(), 15'd0);
    run_queue("idle", 1'b0);
  endtask

  task automatic do_instr(input string tag, input logic [31:0] ins, input int fw, input int mw,
                          input logic zero);
    plan(ins, fw, mw, zero);
    bus.instr_i = ins;
    run_queue(tag, 1'b0);
  endtask

  logic [31:0] pool [6];

  initial begin
    pool[0] = I_ADD; pool[1] = I_ADDI; pool[2] = I_LW;
    pool[3] = I_SW;  pool[4] = I_BEQ;  pool[5] = I_JAL;
    bus.instr_i = I_ADD;
    apply_stimulus(1'b0, 1'b0);

    do_reset();
    do_instr("add", I_ADD, 0, 0, 1'b0);
    do_instr("lw_wait2", I_LW, 0, 2, 1'b0);
    do_instr("beq_taken", I_BEQ, 0, 0, 1'b1);
    do_instr("beq_not", I_BEQ, 0, 0, 1'b0);
    do_instr("sw_timeout", I_SW, 0, MAXW + 5, 1'b0);
    do_instr("jal", I_JAL, 0, 0, 1'b0);
    do_instr("illegal", I_BAD, 0, 0, 1'b0);
`ifdef ILLEGAL_TRAP_EN
    do_reset();
`endif
    do_instr("fetch_edge", I_ADDI, MAXW - 1, 0, 1'b0);
    do_instr("fetch_timeout", I_ADDI, MAXW, 0, 1'b0);
    do_instr("lw_edge", I_LW, 1, MAXW - 1, 1'b0);
    do_instr("lw_timeout", I_LW, 0, MAXW, 1'b0);

    plan(I_SW, 0, 3, 1'b0);
    bus.instr_i = I_SW;
    run_queue("sw_abort", 1'b1);
    do_instr("after_abort", I_ADD, 0, 0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      int fw;
      int mw;
      fw = ($urandom_range(0, 9) == 0) ? MAXW : $urandom_range(0, 3);
      mw = ($urandom_range(0, 7) == 0) ? MAXW : $urandom_range(0, 3);
      do_instr("random", pool[$urandom_range(0, 5)], fw, mw, rnd());
    end
    do_instr("final", I_ADD, 0, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
